// File: rtl/ddr_pkg.sv
// Shared DDR command encodings and scheduler state names.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_ISSUE,
    ST_RECOVER
  } sched_state_t;

  // Largest of the three timing parameters; sizes the shared wait timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr_wait_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
// Latency: load takes effect on the next edge, then one decrement per cycle.
// Backpressure: none; the FSM only samples done while in a wait state.
module ddr_wait_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load overrides counting; count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Arbitrates write/read pool heads and sequences PRE/ACT/RD/WR for one open row.
// Latency: row hit 1 cycle grant-to-RD/WR, empty 1+T_RCD, miss 1+T_RP+T_RCD.
// Backpressure: pool heads are only sampled in IDLE; *_issued pops the granted entry.
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int ROW_BITS   = 4,
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_WR       = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wready,
  input  logic                          wfull,
  input  logic [ADDR_SIZE-1:0]          pool_waddr,
  input  logic                          rready,
  input  logic [ADDR_SIZE-1:0]          pool_raddr,
  output logic                          write_issued,
  output logic                          read_issued,
  output logic [CMD_W-1:0]              cmd,
  output logic [ROW_BITS-1:0]           cmd_row,
  output logic [ADDR_SIZE-ROW_BITS-1:0] cmd_col,
  output logic                          busy
);

  localparam int COL_BITS = ADDR_SIZE - ROW_BITS;
  localparam int TW       = $clog2(max3(T_RP, T_RCD, T_WR)) + 1;
  localparam int SW       = $clog2(STARVE_MAX + 1);

  // Wait states last (len) cycles; the timer is loaded with len-1 on entry.
  localparam logic [TW-1:0] RP_LD  = TW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [TW-1:0] RCD_LD = TW'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [TW-1:0] WR_LD  = TW'(T_WR - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  sched_state_t          state_q, state_d;
  logic                  req_write;
  logic [ROW_BITS-1:0]   req_row;
  logic [COL_BITS-1:0]   req_col;
  logic                  row_open;
  logic [ROW_BITS-1:0]   open_row;
  logic [SW-1:0]         starve_cnt;

  logic                  grant_w, grant_r;
  logic [ADDR_SIZE-1:0]  grant_addr;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_val;
  logic                  tmr_done;

  ddr_wait_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Grant arbitration in IDLE and next-state sequencing of the command flow.
  always_comb begin
    state_d    = state_q;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    grant_addr = pool_raddr;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (wfull) begin
          grant_w = 1'b1;
        end else if (rready && ((starve_cnt < STARVE_LIM) || !wready)) begin
          grant_r = 1'b1;
        end else if (wready) begin
          grant_w = 1'b1;
        end
        grant_addr = grant_w ? pool_waddr : pool_raddr;
        if (grant_w || grant_r) begin
          if (row_open && (open_row == grant_addr[ADDR_SIZE-1 -: ROW_BITS])) begin
            state_d = ST_ISSUE;
          end else if (row_open) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        if (T_RP == 1) begin
          state_d = ST_ACT;
        end else begin
          state_d  = ST_PRE_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RP_LD;
        end
      end
      ST_PRE_WAIT: if (tmr_done) state_d = ST_ACT;
      ST_ACT: begin
        if (T_RCD == 1) begin
          state_d = ST_ISSUE;
        end else begin
          state_d  = ST_ACT_WAIT;
          tmr_load = 1'b1;
          tmr_val  = RCD_LD;
        end
      end
      ST_ACT_WAIT: if (tmr_done) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (req_write) begin
          state_d  = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = WR_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECOVER: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request, open-row tracking and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_write  <= 1'b0;
      req_row    <= '0;
      req_col    <= '0;
      row_open   <= 1'b0;
      open_row   <= '0;
      starve_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (grant_w || grant_r) begin
        req_write <= grant_w;
        req_row   <= grant_addr[ADDR_SIZE-1 -: ROW_BITS];
        req_col   <= grant_addr[COL_BITS-1:0];
      end
      if (grant_w) begin
        starve_cnt <= '0;
      end else if (grant_r && wready && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (state_q == ST_PRE) begin
        row_open <= 1'b0;
      end else if (state_q == ST_ACT) begin
        row_open <= 1'b1;
        open_row <= req_row;
      end
    end
  end

  // Moore output decode from registered state and request fields.
  always_comb begin
    cmd          = CMD_NOP;
    cmd_row      = '0;
    cmd_col      = '0;
    write_issued = 1'b0;
    read_issued  = 1'b0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_PRE: cmd = CMD_PRE;
      ST_ACT: begin
        cmd     = CMD_ACT;
        cmd_row = req_row;
      end
      ST_ISSUE: begin
        cmd          = req_write ? CMD_WR : CMD_RD;
        cmd_col      = req_col;
        write_issued = req_write;
        read_issued  = !req_write;
      end
      default: cmd = CMD_NOP;
    endcase
  end

endmodule

// File: doc/ddr_cmd_scheduler.md
# ddr_cmd_scheduler

Sequences DDR commands for the controller by arbitrating between the head of the write command pool and the head of the read command pool. Tracks a single open row and emits PRE/ACT/RD/WR with tRP, tRCD and tWR spacing. Pulses `write_issued`/`read_issued` to pop the serviced pool entry. Sits between the command pools and the PHY command interface.

## Interface
- `ADDR_SIZE`, 8, pool address width
- `ROW_BITS`, 4, upper address bits forming the row; the remaining `ADDR_SIZE-ROW_BITS` bits form the column
- `T_RP`, 2, cycles from PRE to the next command (≥1)
- `T_RCD`, 2, cycles from ACT to RD/WR (≥1)
- `T_WR`, 3, write recovery cycles after WR before the next command (≥1)
- `STARVE_MAX`, 4, maximum consecutive read grants while a write is pending
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `wready`  in  1  write pool holds a valid head entry
- `wfull`  in  1  write pool full
- `pool_waddr`  in  ADDR_SIZE  write pool head address
- `rready`  in  1  read pool holds a valid head entry
- `pool_raddr`  in  ADDR_SIZE  read pool head address
- `write_issued`  out  1  one-cycle pop to the write pool
- `read_issued`  out  1  one-cycle pop to the read pool
- `cmd`  out  3  command: NOP=0, ACT=1, RD=2, WR=3, PRE=4
- `cmd_row`  out  ROW_BITS  row for ACT; 0 otherwise
- `cmd_col`  out  ADDR_SIZE-ROW_BITS  column for RD/WR; 0 otherwise
- `busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ISSUE, RECOVER.
- Grant in IDLE, evaluated in priority order:
  - If `wfull`, grant write.
  - Else if `rready` and (`starve_cnt < STARVE_MAX` or `!wready`), grant read.
  - Else if `wready`, grant write.
  - Else stay in IDLE.
- On grant, latch the direction and address into `req_row`/`req_col`. Pool heads are not sampled again until the next IDLE.
- Transitions out of IDLE on grant:
  - Row open and `open_row == req_row`: go to ISSUE.
  - Row open and rows differ: go to PRE.
  - No row open: go to ACT.
- PRE: drive `cmd=PRE` and clear `row_open`. Go to PRE_WAIT for `T_RP-1` cycles, or straight to ACT if `T_RP==1`.
- ACT: drive `cmd=ACT` with `cmd_row=req_row`. Set `row_open=1` and `open_row=req_row`. Go to ACT_WAIT for `T_RCD-1` cycles, or to ISSUE if `T_RCD==1`.
- ISSUE: drive `cmd` = RD or WR with `cmd_col=req_col`, and assert the matching `*_issued` for exactly this cycle.
  - After a write, go to RECOVER for `T_WR` cycles, then IDLE.
  - After a read, go to IDLE.
- Starvation counter `starve_cnt`, range 0..STARVE_MAX:
  - Increments (saturating) on a read grant while `wready`.
  - Clears on any write grant.
  - Holds otherwise.
- The open row persists across requests. There is no auto-precharge.
- Reset (asynchronous, any state including mid-sequence): state=IDLE, `row_open=0`, `open_row=0`, `starve_cnt=0`, latched request cleared. All outputs read 0 (`cmd=NOP`). Partially sequenced requests are abandoned without a pop. Pool entries remain and are re-arbitrated.

## Timing
- Outputs are Moore, decoded from registered state and registered request fields. Nothing is combinational from inputs.
- Row hit: grant in IDLE at cycle N, RD/WR at N+1.
- Row empty: ACT at N+1, RD/WR at N+1+T_RCD.
- Row miss: PRE at N+1, ACT at N+1+T_RP, RD/WR at N+1+T_RP+T_RCD.
- Back-to-back read hits issue every 2 cycles (ISSUE→IDLE→ISSUE).
- After WR, the next command is no earlier than T_WR+2 cycles later.
- The pool pops on the rising edge that ends the ISSUE cycle. The pool must present its new head by the following IDLE cycle.
- `wready`/`rready` dropping after grant has no effect; the latched request completes.
- `wfull` and `rready` together: write wins regardless of `starve_cnt`.

## Structure
- `ddr_pkg` holds:
  - `cmd_t` enum (NOP/ACT/RD/WR/PRE, 3 bits)
  - `sched_state_t` enum
  - a `localparam` for the command width
- Shared with the PHY interface and the pools' testbenches.
- One sub-module, `ddr_wait_timer`: loadable down-counter with a `done` flag, used for the PRE_WAIT, ACT_WAIT and RECOVER waits. Width is `$clog2` of the maximum of the three timing parameters, plus 1.

## Test plan
- Reset then idle: all outputs 0 and `busy=0` for 5 cycles.
- `rready=1`, `pool_raddr=8'h25`, empty bank, default params:
  - ACT with `cmd_row=2` one cycle after grant.
  - RD with `cmd_col=5` two cycles later, with `read_issued` high for exactly 1 cycle.
- Open row 2, then `pool_waddr=8'h27`: WR with `cmd_col=7` one cycle after grant (no PRE/ACT), then 3 RECOVER cycles.
- Open row 2, then read `8'h41`:
  - Sequence PRE, wait, ACT with row 4, wait, RD with col 1.
  - RD lands 5 cycles after grant.
- `rready` and `wready` held high continuously, all row hits:
  - Grant order is R,R,R,R,W repeating (`STARVE_MAX=4`).
  - With `wfull` also high, every grant is W.
- Assert `rst` during ACT_WAIT:
  - Immediately `cmd=NOP` and no `*_issued` pulse.
  - After release, the same request re-issues ACT, confirming `row_open` was cleared.
